video_cfg_seq: RTL

VIDEO_CFG_SEQ -- requirements
Module: video_cfg_seq

---
 rtl/video_cfg_pkg.sv | 44 ++++
 rtl/video_cfg_rom.sv | 27 ++
 rtl/video_cfg_seq.sv | 94 +++++++++
 3 files changed

// File: rtl/video_cfg_pkg.sv
// video_cfg_pkg: register map, preset timing table and sequencer state encoding shared by video_cfg_seq and video_cfg_rom.
package video_cfg_pkg;
  localparam int PRESET_COUNT = 4;
  localparam logic [3:0] W_HRES = 4'd0, W_HFP = 4'd1, W_HSW = 4'd2, W_HBP = 4'd3;
  localparam logic [3:0] W_VRES = 4'd4, W_VFP = 4'd5, W_VSW = 4'd6, W_VBP = 4'd7;
  localparam logic [3:0] W_SYNC = 4'd8, W_WPL = 4'd9, W_MODE = 4'd10;
  typedef enum logic [2:0] {IDLE, WRITE, SYNC_SET, WAIT_ACK, SYNC_CLR, WAIT_NACK, FINISH} state_t;
  typedef struct packed {
    logic        double_x;
    logic [10:0] res_x;
    logic [10:0] hs_fp;
    logic [10:0] hs_w;
    logic [10:0] hs_bp;
    logic        double_y;
    logic        crtlook;
    logic [10:0] res_y;
    logic [10:0] vs_fp;
    logic [10:0] vs_w;
    logic [10:0] vs_bp;
    logic [7:0]  wpl_m1;
    logic        hires;
    logic [2:0]  bpp;
    logic        ext_pal;
    logic [10:0] cursor_x_offset;
  } preset_t;
  localparam preset_t PRESETS [PRESET_COUNT] = '{
    '{double_x: 1'b0, res_x: 11'd640, hs_fp: 11'd40, hs_w: 11'd20, hs_bp: 11'd68,
      double_y: 1'b1, crtlook: 1'b0, res_y: 11'd256, vs_fp: 11'd40, vs_w: 11'd5, vs_bp: 11'd67,
      wpl_m1: 8'd79, hires: 1'b0, bpp: 3'd2, ext_pal: 1'b0, cursor_x_offset: 11'd217},
    '{double_x: 1'b0, res_x: 11'd1152, hs_fp: 11'd40, hs_w: 11'd20, hs_bp: 11'd62,
      double_y: 1'b0, crtlook: 1'b0, res_y: 11'd896, vs_fp: 11'd4, vs_w: 11'd3, vs_bp: 11'd47,
      wpl_m1: 8'd35, hires: 1'b1, bpp: 3'd0, ext_pal: 1'b0, cursor_x_offset: 11'd272},
    '{double_x: 1'b0, res_x: 11'd800, hs_fp: 11'd40, hs_w: 11'd128, hs_bp: 11'd88,
      double_y: 1'b0, crtlook: 1'b0, res_y: 11'd600, vs_fp: 11'd1, vs_w: 11'd4, vs_bp: 11'd23,
      wpl_m1: 8'd99, hires: 1'b0, bpp: 3'd3, ext_pal: 1'b1, cursor_x_offset: 11'd200},
    '{double_x: 1'b1, res_x: 11'd1024, hs_fp: 11'd24, hs_w: 11'd136, hs_bp: 11'd160,
      double_y: 1'b0, crtlook: 1'b1, res_y: 11'd768, vs_fp: 11'd3, vs_w: 11'd6, vs_bp: 11'd29,
      wpl_m1: 8'd127, hires: 1'b0, bpp: 3'd1, ext_pal: 1'b0, cursor_x_offset: 11'd296}
  };
  // Word 8 is the sync handshake register, so the write pass skips it.
  function automatic logic [3:0] write_word(input logic [3:0] i);
    return (i < 4'd8) ? i : i + 4'd1;
  endfunction
endpackage

// File: rtl/video_cfg_rom.sv
// video_cfg_rom: combinational preset/word lookup producing the register file write data.
module video_cfg_rom import video_cfg_pkg::*; #(
  parameter int NUM_PRESETS = PRESET_COUNT
) (
  input  logic [$clog2(NUM_PRESETS)-1:0] preset,
  input  logic [3:0]                     word,
  output logic [31:0]                    data
);
  preset_t p;
  assign p = PRESETS[preset];
  always_comb begin
    data = '0;
    case (word)
      W_HRES: data = {p.double_x, 20'h0, p.res_x};
      W_HFP:  data = {21'h0, p.hs_fp};
      W_HSW:  data = {21'h0, p.hs_w};
      W_HBP:  data = {21'h0, p.hs_bp};
      W_VRES: data = {p.double_y, p.crtlook, 19'h0, p.res_y};
      W_VFP:  data = {21'h0, p.vs_fp};
      W_VSW:  data = {21'h0, p.vs_w};
      W_VBP:  data = {21'h0, p.vs_bp};
      W_WPL:  data = {24'h0, p.wpl_m1};
      W_MODE: data = {p.hires, p.bpp, p.ext_pal, 16'h0, p.cursor_x_offset};
      default: data = '0;
    endcase
  end
endmodule

// File: rtl/video_cfg_seq.sv
// video_cfg_seq: loads a preset into the video config register file, then runs the sync set/ack/clear handshake.
// Define VIDEO_CFG_SEQ_TIMEOUT_EN to bound each wait state by TIMEOUT_CYCLES and abort with err.
module video_cfg_seq import video_cfg_pkg::*; #(
  parameter int NUM_PRESETS = PRESET_COUNT
`ifdef VIDEO_CFG_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic [$clog2(NUM_PRESETS)-1:0] mode_sel,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [31:0]                    reg_wdata,
  output logic [5:0]                     reg_addr,
  output logic                           reg_wstrobe,
  input  logic [31:0]                    reg_rdata
);
  localparam logic [5:0] SYNC_ADDR = {W_SYNC, 2'b00};
  state_t state, state_n;
  logic [3:0] idx, word;
  logic [$clog2(NUM_PRESETS)-1:0] sel;
  logic [31:0] rom_data;
  logic timeout, hit, abort;
  logic unused_rdata;
  assign unused_rdata = ^{reg_rdata[31:2], reg_rdata[0]};
  assign word = write_word(idx);
  video_cfg_rom #(.NUM_PRESETS(NUM_PRESETS)) u_rom (.preset(sel), .word(word), .data(rom_data));
`ifdef VIDEO_CFG_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES);
  // Restarts at zero on every entry into a wait state.
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= ((state == WAIT_ACK || state == WAIT_NACK) && state_n == state) ? cnt + 1'b1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      sel   <= '0;
    end else begin
      state <= state_n;
      idx   <= (state == WRITE) ? idx + 4'd1 : '0;
      sel   <= (state == IDLE && req) ? mode_sel : sel;
    end
  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    reg_wstrobe = 1'b0;
    reg_addr    = '0;
    reg_wdata   = '0;
    hit         = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: state_n = req ? WRITE : IDLE;
      WRITE: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = {word, 2'b00};
        reg_wdata   = rom_data;
        state_n     = (idx == 4'd9) ? SYNC_SET : WRITE;
      end
      SYNC_SET, SYNC_CLR: begin
        busy        = 1'b1;
        reg_wstrobe = 1'b1;
        reg_addr    = SYNC_ADDR;
        reg_wdata   = (state == SYNC_SET) ? 32'h1 : 32'h0;
        state_n     = (state == SYNC_SET) ? WAIT_ACK : WAIT_NACK;
      end
      WAIT_ACK, WAIT_NACK: begin
        reg_addr    = SYNC_ADDR;
        hit         = (state == WAIT_ACK) == reg_rdata[1];
        abort       = timeout && !hit;
        busy        = !abort;
        reg_wstrobe = abort;
        err         = abort;
        state_n     = hit ? ((state == WAIT_ACK) ? SYNC_CLR : FINISH) : abort ? IDLE : state;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
